// File: rtl/fft_butterfly_r2_fx.sv
// Fixed-point radix-2 DIT butterfly: out0 = X + Y*W, out1 = X - Y*W (optional conj(W), /2, saturation).
// Latency 4 cycles; a held output (out_valid && !out_ready) stalls the whole pipe and drops in_ready.
module fft_butterfly_r2_fx #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   x_real,
  input  logic [DW-1:0]   x_imag,
  input  logic [DW-1:0]   y_real,
  input  logic [DW-1:0]   y_imag,
  input  logic [TW-1:0]   w_real,
  input  logic [TW-1:0]   w_imag,
  input  logic            inv,
  input  logic            scale,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out0_real,
  output logic [DW-1:0]   out0_imag,
  output logic [DW-1:0]   out1_real,
  output logic [DW-1:0]   out1_imag,
  output logic [TAGW-1:0] tag_out,
  output logic            ovf,
  input  logic            clr_ovf
);

  localparam int PW = DW + TW;
  localparam int SW = DW + TW + 1;
  localparam int RW = DW + 2;

  localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
  localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [RW-1:0] D_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] D_MIN = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] RND   = SW'(1) << (TW - 2);

  logic ce;

  assign ce       = !(out_valid && !out_ready);
  assign in_ready = ce;

  function automatic logic is_sat(input logic signed [RW-1:0] v);
    return (v > D_MAX) || (v < D_MIN);
  endfunction

  function automatic logic [DW-1:0] clip(input logic signed [RW-1:0] v);
    if (v > D_MAX) return D_MAX[DW-1:0];
    if (v < D_MIN) return D_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  // S1: input register; conj(W) negates Wi, clamping -1.0 to the largest positive code
  logic                 v1;
  logic signed [DW-1:0] x1_re, x1_im, y1_re, y1_im;
  logic signed [TW-1:0] w1_re, w1_im;
  logic                 sc1;
  logic [TAGW-1:0]      tag1;
  logic signed [TW-1:0] w_im_eff;

  always_comb begin
    w_im_eff = w_imag;
    if (inv) w_im_eff = (w_imag == W_MIN) ? W_MAX : -w_imag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      x1_re <= '0;
      x1_im <= '0;
      y1_re <= '0;
      y1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
      sc1   <= 1'b0;
      tag1  <= '0;
    end else if (ce) begin
      v1    <= in_valid;
      x1_re <= x_real;
      x1_im <= x_imag;
      y1_re <= y_real;
      y1_im <= y_imag;
      w1_re <= w_real;
      w1_im <= w_im_eff;
      sc1   <= scale;
      tag1  <= tag_in;
    end
  end

  // S2: full-precision partial products
  logic                 v2;
  logic signed [DW-1:0] x2_re, x2_im;
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic                 sc2;
  logic [TAGW-1:0]      tag2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      x2_re <= '0;
      x2_im <= '0;
      m_rr  <= '0;
      m_ii  <= '0;
      m_ri  <= '0;
      m_ir  <= '0;
      sc2   <= 1'b0;
      tag2  <= '0;
    end else if (ce) begin
      v2    <= v1;
      x2_re <= x1_re;
      x2_im <= x1_im;
      m_rr  <= PW'(y1_re) * PW'(w1_re);
      m_ii  <= PW'(y1_im) * PW'(w1_im);
      m_ri  <= PW'(y1_re) * PW'(w1_im);
      m_ir  <= PW'(y1_im) * PW'(w1_re);
      sc2   <= sc1;
      tag2  <= tag1;
    end
  end

  // S3: complex product back to data scale, rounded half-up
  logic                 v3;
  logic signed [DW-1:0] x3_re, x3_im;
  logic signed [RW-1:0] t3_re, t3_im;
  logic                 sc3;
  logic [TAGW-1:0]      tag3;
  logic signed [SW-1:0] acc_re, acc_im;

  always_comb begin
    acc_re = SW'(m_rr) - SW'(m_ii) + RND;
    acc_im = SW'(m_ri) + SW'(m_ir) + RND;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      x3_re <= '0;
      x3_im <= '0;
      t3_re <= '0;
      t3_im <= '0;
      sc3   <= 1'b0;
      tag3  <= '0;
    end else if (ce) begin
      v3    <= v2;
      x3_re <= x2_re;
      x3_im <= x2_im;
      t3_re <= RW'(acc_re >>> (TW - 1));
      t3_im <= RW'(acc_im >>> (TW - 1));
      sc3   <= sc2;
      tag3  <= tag2;
    end
  end

  // S4: sum/difference, optional halving (rounded up), then saturate
  logic signed [RW-1:0] s_re, s_im, d_re, d_im;
  logic                 any_sat;

  always_comb begin
    s_re = RW'(x3_re) + t3_re;
    s_im = RW'(x3_im) + t3_im;
    d_re = RW'(x3_re) - t3_re;
    d_im = RW'(x3_im) - t3_im;
    if (sc3) begin
      s_re = (s_re + RW'(1)) >>> 1;
      s_im = (s_im + RW'(1)) >>> 1;
      d_re = (d_re + RW'(1)) >>> 1;
      d_im = (d_im + RW'(1)) >>> 1;
    end
    any_sat = is_sat(s_re) || is_sat(s_im) || is_sat(d_re) || is_sat(d_im);
  end

  // Bubbles leave the output data untouched so the last pair stays readable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out0_real <= '0;
      out0_imag <= '0;
      out1_real <= '0;
      out1_imag <= '0;
      tag_out   <= '0;
    end else if (ce) begin
      out_valid <= v3;
      if (v3) begin
        out0_real <= clip(s_re);
        out0_imag <= clip(s_im);
        out1_real <= clip(d_re);
        out1_imag <= clip(d_im);
        tag_out   <= tag3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                   ovf <= 1'b0;
    else if (ce && v3 && any_sat) ovf <= 1'b1;
    else if (clr_ovf)             ovf <= 1'b0;
  end

endmodule
